// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - instruction sequencer for the 8-bit ALU
// Reads two operands from an 8x8 register file, runs the ALU for one cycle and writes the result back.
module alu_issue_ctrl #(
  parameter logic [3:0] MUL_CMD = 4'b0100,
  parameter logic [3:0] DIV_CMD = 4'b0101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [12:0] instr,
  input  logic        ld_valid,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_y,
  output logic        done,
  output logic        err,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cmd_q;
  logic [2:0]  rd_q;
  logic [2:0]  ra_q;
  logic [2:0]  rb_q;
  logic        dz_q;
  logic [15:0] res_q;
  logic [7:0]  regs [8];
  logic [2:0]  rd_hi;
  logic        accept;
  logic        ld_en;

  assign instr_ready = (state == S_IDLE) && !rst;
  assign alu_oe      = (state == S_EXEC);
  assign busy        = (state != S_IDLE);
  assign dbg_data    = regs[dbg_addr];
  assign accept      = instr_valid && instr_ready;
  assign ld_en       = ld_valid && (state == S_IDLE) && !rst;
  // High byte of a multiply lands in the next register, wrapping r7 -> r0.
  assign rd_hi       = rd_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cmd_q   <= 4'd0;
      rd_q    <= 3'd0;
      ra_q    <= 3'd0;
      rb_q    <= 3'd0;
      dz_q    <= 1'b0;
      res_q   <= 16'd0;
      alu_a   <= 8'd0;
      alu_b   <= 8'd0;
      alu_cmd <= 4'd0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_en) regs[ld_addr] <= ld_data;
          if (accept) begin
            cmd_q <= instr[12:9];
            rd_q  <= instr[8:6];
            ra_q  <= instr[5:3];
            rb_q  <= instr[2:0];
            state <= S_READ;
          end
        end
        S_READ: begin
          // A same-edge load has already committed, so these reads see it.
          alu_a   <= regs[ra_q];
          alu_b   <= regs[rb_q];
          alu_cmd <= cmd_q;
          dz_q    <= (cmd_q == DIV_CMD) && (regs[rb_q] == 8'd0);
          state   <= S_EXEC;
        end
        S_EXEC: begin
          res_q <= alu_y;
          state <= S_WB;
        end
        default: begin
          if (!dz_q) begin
            regs[rd_q] <= res_q[7:0];
            if (cmd_q == MUL_CMD) regs[rd_hi] <= res_q[15:8];
          end
          done  <= 1'b1;
          err   <= dz_q;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream sequencer for the 8-bit ALU.
- Accepts one instruction word per valid/ready handshake and reads two operands from an internal 8x8 register file.
- Drives the ALU's a/b/cmd/oe inputs, captures its 16-bit result and writes the result back to the register file.
- Also provides a register load port and a combinational debug read port so software and the bench can set and observe state.

Parameters:
- MUL_CMD, 4'b0100, ALU multiply opcode; two-byte writeback.
- DIV_CMD, 4'b0101, ALU divide opcode; divide-by-zero check.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr  in  13  {cmd[12:9], rd[8:6], ra[5:3], rb[2:0]}
- ld_valid  in  1  register load request
- ld_addr  in  3  load target register
- ld_data  in  8  load value
- alu_a  out  8  ALU operand a (registered)
- alu_b  out  8  ALU operand b (registered)
- alu_cmd  out  4  ALU opcode (registered)
- alu_oe  out  1  ALU output enable
- alu_y  in  16  ALU result
- done  out  1  one-cycle pulse: instruction retired
- err  out  1  valid with done: divide by zero, writeback suppressed
- busy  out  1  FSM not in IDLE
- dbg_addr  in  3  debug read address
- dbg_data  out  8  regfile[dbg_addr], combinational

Behaviour:
- Reset (sampled on rising clk while rst=1):
  - FSM to IDLE; all 8 registers to 0x00.
  - alu_a=alu_b=0x00, alu_cmd=4'b0000, alu_oe=0, done=0, err=0, busy=0.
  - instr_ready=0 while rst is high.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE, unconditional after accept.
- IDLE:
  - instr_ready=1. Accept when instr_valid && instr_ready; latch cmd/rd/ra/rb; go to READ.
- READ:
  - alu_a <= reg[ra], alu_b <= reg[rb], alu_cmd <= cmd.
  - Record dz = (cmd==DIV_CMD && reg[rb]==0). Go to EXEC.
- EXEC:
  - alu_oe=1, driven combinationally from state (high only in EXEC).
  - res <= alu_y at the end of EXEC. Go to WB.
- WB:
  - If dz: no write.
  - Else reg[rd] <= res[7:0]; if cmd==MUL_CMD also reg[(rd+1) mod 8] <= res[15:8] (rd=7 wraps to r0).
  - All other opcodes: res[15:8] is discarded. SUB underflow gives the wrapped low byte.
  - Go to IDLE. On the same edge set done<=1 and err<=dz.
- done/err:
  - Registered; high exactly one cycle, coincident with the first IDLE cycle after WB.
  - err is 0 whenever done is 0.
- Latency and throughput:
  - Accept edge N → done high in the cycle after edge N+3.
  - Written value visible on dbg_data in that same cycle.
  - Throughput: 1 instruction / 4 cycles. Back-to-back accept is allowed on the cycle done is high.
- Hazards:
  - Operands are read in READ, before WB, so rd==ra or rd==rb is safe.
  - No forwarding is needed; execution is single-issue.
- Load port:
  - ld_valid honoured only in IDLE (not in reset); ignored in READ/EXEC/WB. No backpressure.
  - Load and instruction accept may occur on the same edge. The load commits first; the instruction's READ sees the loaded value.
- instr_valid while busy: ignored, and instr must be held by the sender until accepted.
- Reset mid-operation (any state):
  - Abort with no writeback and no done pulse.
  - Outputs and registers return to reset values on that edge.

Test Plan:
- Load r1=0x0F, r2=0xF0; ADD (cmd 0000, rd=3, ra=1, rb=2) → alu_oe high exactly 1 cycle; done 4 cycles after accept; r3=0xFF; err=0.
- Load r1=0x10, r2=0x20; MUL rd=7 ra=1 rb=2 → r7=0x00, r0=0x02 (wrap); done=1, err=0.
- Load r4=0x05, r5=0x07; SUB rd=4 ra=4 rb=5 → r4=0xFE; a following ADD rd=6 ra=4 rb=4 issued back-to-back on the done cycle → r6=0xFC.
- Load r1=0x09, r2=0x00; DIV rd=1 ra=1 rb=2 → done=1 with err=1; r1 stays 0x09; next instruction has err=0.
- ld_valid (r2=0x33) during EXEC → ignored. ld (r2=0x33) and instr accept (BUF rd=5 ra=2) on the same edge → r5=0x33.
- Assert rst for 1 cycle while in EXEC → no done pulse; all regs 0x00; alu_oe=0; instr_ready=0 during reset and 1 the cycle after.
